hfg_feature_buffer: RTL and testbench

- Ping-pong feature buffer on the receiving end of the Haar feature generator's FBR write interface.
- Captures one window's feature set (up to 128 × 32-bit features) per bank, then hands the completed bank to the cascade classifier for random-access reads.
- Back-pressures the generator through oReady while both banks are occupied.

---
 rtl/hfg_pkg.sv | 15 +
 rtl/hfg_fb_bank.sv | 48 ++++
 rtl/hfg_feature_buffer.sv | 110 +++++++++++
 tb/tb_hfg_feature_buffer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/hfg_pkg.sv
// Shared sizing for the Haar feature buffer slice: feature word, index and
// window-counter widths, plus the counter step helper.
package hfg_pkg;
  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 7;
  localparam int DEPTH     = 128;
  localparam int WIN_CNT_W = 16;

  function automatic logic [WIN_CNT_W-1:0] win_cnt_next(
    input logic [WIN_CNT_W-1:0] cnt,
    input logic                 inc
  );
    win_cnt_next = cnt + {{(WIN_CNT_W-1){1'b0}}, inc};
  endfunction
endpackage

// File: rtl/hfg_fb_bank.sv
// One feature bank: simple dual-port RAM with a single write port and a
// registered read port whose output register clears on reset.
module hfg_fb_bank #(
  parameter int DW    = 32,
  parameter int AW    = 7,
  parameter int DEPTH = 128
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_d;
  logic [DW-1:0] rdata_q;

  // Storage array; never reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Read register only advances on a read so the last value is held.
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem_q[raddr];
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Output register of the read port.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= {DW{1'b0}};
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/hfg_feature_buffer.sv
// Ping-pong feature buffer between the Haar feature generator (writer) and
// the cascade classifier (random-access reader).
module hfg_feature_buffer
  import hfg_pkg::*;
(
  input  logic                 iClk,
  input  logic                 iReset,
  input  logic                 iWrreq_FBR,
  input  logic [ADDR_W-1:0]    iAddr_FBR,
  input  logic [DATA_W-1:0]    iFeature,
  input  logic                 iFull_FBR,
  output logic                 oReady,
  input  logic                 iRdreq,
  input  logic [ADDR_W-1:0]    iAddr_Rd,
  input  logic                 iRelease,
  output logic                 oAvail,
  output logic [DATA_W-1:0]    oFeature,
  output logic                 oRdvalid,
  output logic [WIN_CNT_W-1:0] oWin_cnt,
  output logic                 oOverflow,
  output logic                 oUnderflow
);
  logic [1:0]           full_d, full_q;
  logic                 wr_sel_d, wr_sel_q;
  logic                 rd_sel_d, rd_sel_q;
  logic                 rd_bank_d, rd_bank_q;
  logic                 rdvalid_d, rdvalid_q;
  logic [WIN_CNT_W-1:0] win_cnt_d, win_cnt_q;
  logic                 overflow_d, overflow_q;
  logic                 underflow_d, underflow_q;

  logic                 wr_ok, rd_ok, do_full, do_release, rd_fire;
  logic [1:0]           bank_we, bank_re;
  logic [DATA_W-1:0]    rdata0, rdata1;

  // Next-state logic; full/release are judged on pre-edge flags so both
  // can apply in one cycle without ever landing on the same bank.
  always_comb begin
    wr_ok       = ~full_q[wr_sel_q];
    rd_ok       = full_q[rd_sel_q];
    do_full     = iFull_FBR & wr_ok;
    do_release  = iRelease & rd_ok;
    rd_fire     = iRdreq & rd_ok;
    full_d      = full_q;
    wr_sel_d    = wr_sel_q;
    rd_sel_d    = rd_sel_q;
    if (do_full) begin
      full_d[wr_sel_q] = 1'b1;
      wr_sel_d         = ~wr_sel_q;
    end else begin
      wr_sel_d         = wr_sel_q;
    end
    if (do_release) begin
      full_d[rd_sel_q] = 1'b0;
      rd_sel_d         = ~rd_sel_q;
    end else begin
      rd_sel_d         = rd_sel_q;
    end
    bank_we[0]  = iWrreq_FBR & wr_ok & ~wr_sel_q;
    bank_we[1]  = iWrreq_FBR & wr_ok & wr_sel_q;
    bank_re[0]  = rd_fire & ~rd_sel_q;
    bank_re[1]  = rd_fire & rd_sel_q;
    rdvalid_d   = rd_fire;
    rd_bank_d   = rd_fire ? rd_sel_q : rd_bank_q;
    win_cnt_d   = win_cnt_next(win_cnt_q, do_full);
    overflow_d  = overflow_q | ((iWrreq_FBR | iFull_FBR) & ~wr_ok);
    underflow_d = underflow_q | ((iRdreq | iRelease) & ~rd_ok);
  end

  // Control and status registers.
  always_ff @(posedge iClk) begin
    if (iReset) begin
      full_q      <= 2'b00;
      wr_sel_q    <= 1'b0;
      rd_sel_q    <= 1'b0;
      rd_bank_q   <= 1'b0;
      rdvalid_q   <= 1'b0;
      win_cnt_q   <= {WIN_CNT_W{1'b0}};
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      full_q      <= full_d;
      wr_sel_q    <= wr_sel_d;
      rd_sel_q    <= rd_sel_d;
      rd_bank_q   <= rd_bank_d;
      rdvalid_q   <= rdvalid_d;
      win_cnt_q   <= win_cnt_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  hfg_fb_bank #(.DW(DATA_W), .AW(ADDR_W), .DEPTH(DEPTH)) u_bank0 (
    .clk(iClk), .rst(iReset), .we(bank_we[0]), .waddr(iAddr_FBR), .wdata(iFeature),
    .re(bank_re[0]), .raddr(iAddr_Rd), .rdata(rdata0)
  );

  hfg_fb_bank #(.DW(DATA_W), .AW(ADDR_W), .DEPTH(DEPTH)) u_bank1 (
    .clk(iClk), .rst(iReset), .we(bank_we[1]), .waddr(iAddr_FBR), .wdata(iFeature),
    .re(bank_re[1]), .raddr(iAddr_Rd), .rdata(rdata1)
  );

  assign oReady     = ~full_q[wr_sel_q];
  assign oAvail     = full_q[rd_sel_q];
  assign oFeature   = rd_bank_q ? rdata1 : rdata0;
  assign oRdvalid   = rdvalid_q;
  assign oWin_cnt   = win_cnt_q;
  assign oOverflow  = overflow_q;
  assign oUnderflow = underflow_q;
endmodule

// File: tb/tb_hfg_feature_buffer.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// queue-of-completed-banks reference model.
module tb_hfg_feature_buffer;
  logic        iClk = 1'b0;
  logic        iReset, iWrreq_FBR, iFull_FBR, iRdreq, iRelease;
  logic [6:0]  iAddr_FBR, iAddr_Rd;
  logic [31:0] iFeature;
  logic        oReady, oAvail, oRdvalid, oOverflow, oUnderflow;
  logic [31:0] oFeature;
  logic [15:0] oWin_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: bank contents, FIFO of completed banks awaiting reads.
  logic [31:0] mmem [2][128];
  int          q[$];
  int          nwin;
  logic [15:0] m_cnt;
  logic        m_ovf, m_unf, m_rdv;
  logic [31:0] m_feat;

  hfg_feature_buffer dut (
    .iClk(iClk), .iReset(iReset), .iWrreq_FBR(iWrreq_FBR), .iAddr_FBR(iAddr_FBR),
    .iFeature(iFeature), .iFull_FBR(iFull_FBR), .oReady(oReady), .iRdreq(iRdreq),
    .iAddr_Rd(iAddr_Rd), .iRelease(iRelease), .oAvail(oAvail), .oFeature(oFeature),
    .oRdvalid(oRdvalid), .oWin_cnt(oWin_cnt), .oOverflow(oOverflow), .oUnderflow(oUnderflow)
  );

  always #5 iClk = ~iClk;

  task automatic idle_inputs();
    iWrreq_FBR = 1'b0; iAddr_FBR = 7'd0; iFeature = 32'd0; iFull_FBR = 1'b0;
    iRdreq = 1'b0; iAddr_Rd = 7'd0; iRelease = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    iReset = 1'b1;
    q.delete(); nwin = 0; m_cnt = 16'd0; m_ovf = 1'b0; m_unf = 1'b0;
    m_rdv = 1'b0; m_feat = 32'd0;
    @(posedge iClk); #1;
    iReset = 1'b0;
  endtask

  task automatic step(input logic wr, input logic [6:0] wa, input logic [31:0] wd,
                      input logic fl, input logic rd, input logic [6:0] ra, input logic rel);
    bit ready, avail;
    int wb, rb;
    iWrreq_FBR = wr; iAddr_FBR = wa; iFeature = wd; iFull_FBR = fl;
    iRdreq = rd; iAddr_Rd = ra; iRelease = rel;
    ready = (q.size() < 2);
    avail = (q.size() > 0);
    wb    = nwin % 2;
    rb    = avail ? q[0] : 0;
    if (rd && avail) begin m_feat = mmem[rb][ra]; m_rdv = 1'b1; end
    else begin m_rdv = 1'b0; if (rd) m_unf = 1'b1; end
    if (wr) begin if (ready) mmem[wb][wa] = wd; else m_ovf = 1'b1; end
    if (fl) begin
      if (ready) begin q.push_back(wb); nwin++; m_cnt = m_cnt + 16'd1; end
      else m_ovf = 1'b1;
    end
    if (rel) begin if (avail) void'(q.pop_front()); else m_unf = 1'b1; end
    @(posedge iClk); #1;
    idle_inputs();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({oReady, oAvail, oRdvalid, oOverflow, oUnderflow} !== 5'b10000) begin
      errors++; $display("FAIL reset_status: got %b exp %b",
        {oReady, oAvail, oRdvalid, oOverflow, oUnderflow}, 5'b10000);
    end
    checks++;
    if ({oWin_cnt, oFeature} !== 48'd0) begin
      errors++; $display("FAIL reset_data: cnt %h feat %h exp 0", oWin_cnt, oFeature);
    end
  endtask

  task automatic test_fill_read();
    for (int a = 0; a < 128; a++) step(1'b1, 7'(a), 32'h1000 + 32'(a), 1'b0, 1'b0, 7'd0, 1'b0);
    step(1'b0, 7'd0, 32'd0, 1'b1, 1'b0, 7'd0, 1'b0);
    checks++;
    if ({oAvail, oReady, oWin_cnt} !== {2'b11, 16'd1}) begin
      errors++; $display("FAIL fill_status: avail %b ready %b cnt %0d exp 1 1 1", oAvail, oReady, oWin_cnt);
    end
    step(1'b0, 7'd0, 32'd0, 1'b0, 1'b1, 7'd5, 1'b0);
    checks++;
    if ({oRdvalid, oFeature} !== {1'b1, 32'h00001005}) begin
      errors++; $display("FAIL read5: rdvalid %b feat %h exp 1 00001005", oRdvalid, oFeature);
    end
  endtask

  task automatic test_overflow();
    for (int a = 0; a < 128; a++) step(1'b1, 7'(a), 32'h2000 + 32'(a), 1'b0, 1'b0, 7'd0, 1'b0);
    step(1'b0, 7'd0, 32'd0, 1'b1, 1'b0, 7'd0, 1'b0);
    checks++;
    if ({oReady, oAvail, oWin_cnt, oOverflow} !== {2'b01, 16'd2, 1'b0}) begin
      errors++; $display("FAIL both_full: ready %b avail %b cnt %0d ovf %b exp 0 1 2 0",
        oReady, oAvail, oWin_cnt, oOverflow);
    end
    step(1'b1, 7'd3, 32'h0000DEAD, 1'b0, 1'b0, 7'd0, 1'b0);
    checks++;
    if ({oOverflow, oReady, oWin_cnt} !== {2'b10, 16'd2}) begin
      errors++; $display("FAIL ovf_write: ovf %b ready %b cnt %0d exp 1 0 2", oOverflow, oReady, oWin_cnt);
    end
    step(1'b0, 7'd0, 32'd0, 1'b0, 1'b1, 7'd3, 1'b0);
    checks++;
    if (oFeature !== 32'h00001003) begin
      errors++; $display("FAIL ovf_bank0_intact: got %h exp 00001003", oFeature);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 7'd0, 32'd0, 1'b0, 1'b1, 7'(i), 1'b0);
      checks++;
      if ({oRdvalid, oFeature} !== {1'b1, 32'h1000 + 32'(i)}) begin
        errors++; $display("FAIL b2b_read%0d: rdvalid %b feat %h exp 1 %h", i, oRdvalid, oFeature, 32'h1000 + 32'(i));
      end
    end
    step(1'b0, 7'd0, 32'd0, 1'b0, 1'b0, 7'd0, 1'b0);
    checks++;
    if ({oRdvalid, oFeature} !== {1'b0, 32'h00001002}) begin
      errors++; $display("FAIL b2b_hold: rdvalid %b feat %h exp 0 00001002", oRdvalid, oFeature);
    end
  endtask

  task automatic test_full_release_same_cycle();
    step(1'b0, 7'd0, 32'd0, 1'b1, 1'b0, 7'd0, 1'b1);
    checks++;
    if ({oOverflow, oReady, oAvail, oWin_cnt} !== {3'b111, 16'd2}) begin
      errors++; $display("FAIL full_rel: ovf %b ready %b avail %b cnt %0d exp 1 1 1 2",
        oOverflow, oReady, oAvail, oWin_cnt);
    end
    step(1'b0, 7'd0, 32'd0, 1'b0, 1'b1, 7'd3, 1'b1);
    checks++;
    if ({oRdvalid, oFeature, oAvail} !== {1'b1, 32'h00002003, 1'b0}) begin
      errors++; $display("FAIL bank1_intact: rdvalid %b feat %h avail %b exp 1 00002003 0",
        oRdvalid, oFeature, oAvail);
    end
  endtask

  task automatic test_underflow();
    step(1'b0, 7'd0, 32'd0, 1'b0, 1'b1, 7'd9, 1'b1);
    checks++;
    if ({oRdvalid, oUnderflow, oAvail, oReady, oFeature} !== {4'b0101, 32'h00002003}) begin
      errors++; $display("FAIL underflow: rdvalid %b unf %b avail %b ready %b feat %h exp 0 1 0 1 00002003",
        oRdvalid, oUnderflow, oAvail, oReady, oFeature);
    end
  endtask

  task automatic test_reset_mid_window();
    for (int a = 0; a < 40; a++) step(1'b1, 7'(a), $urandom, 1'b0, 1'b0, 7'd0, 1'b0);
    do_reset();
    checks++;
    if ({oReady, oAvail, oOverflow, oUnderflow, oWin_cnt} !== {4'b1000, 16'd0}) begin
      errors++; $display("FAIL mid_reset: ready %b avail %b ovf %b unf %b cnt %0d exp 1 0 0 0 0",
        oReady, oAvail, oOverflow, oUnderflow, oWin_cnt);
    end
    for (int a = 0; a < 128; a++) step(1'b1, 7'(a), 32'h3000 + 32'(a), 1'b0, 1'b0, 7'd0, 1'b0);
    step(1'b0, 7'd0, 32'd0, 1'b1, 1'b0, 7'd0, 1'b0);
    step(1'b0, 7'd0, 32'd0, 1'b0, 1'b1, 7'd7, 1'b0);
    checks++;
    if ({oRdvalid, oFeature, oWin_cnt} !== {1'b1, 32'h00003007, 16'd1}) begin
      errors++; $display("FAIL post_reset_read7: rdvalid %b feat %h cnt %0d exp 1 00003007 1",
        oRdvalid, oFeature, oWin_cnt);
    end
    step(1'b0, 7'd0, 32'd0, 1'b0, 1'b1, 7'd127, 1'b1);
    checks++;
    if ({oRdvalid, oFeature, oAvail} !== {1'b1, 32'h0000307F, 1'b0}) begin
      errors++; $display("FAIL post_reset_read127: rdvalid %b feat %h avail %b exp 1 0000307f 0",
        oRdvalid, oFeature, oAvail);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 4000; n++) begin
      step(1'($urandom_range(0, 1)), 7'($urandom), $urandom, 1'($urandom_range(0, 15) == 0),
           1'($urandom_range(0, 1)), 7'($urandom), 1'($urandom_range(0, 11) == 0));
      checks++;
      if ({oReady, oAvail, oRdvalid, oOverflow, oUnderflow} !==
          {q.size() < 2, q.size() > 0, m_rdv, m_ovf, m_unf}) begin
        errors++; $display("FAIL rand_status@%0d: got %b exp %b", n,
          {oReady, oAvail, oRdvalid, oOverflow, oUnderflow},
          {q.size() < 2, q.size() > 0, m_rdv, m_ovf, m_unf});
      end
      checks++;
      if ({oFeature, oWin_cnt} !== {m_feat, m_cnt}) begin
        errors++; $display("FAIL rand_data@%0d: feat %h cnt %0d exp %h %0d", n, oFeature, oWin_cnt, m_feat, m_cnt);
      end
    end
  endtask

  task automatic test_win_cnt_wrap();
    do_reset();
    step(1'b0, 7'd0, 32'd0, 1'b1, 1'b0, 7'd0, 1'b0);
    for (int n = 1; n < 65535; n++) step(1'b0, 7'd0, 32'd0, 1'b1, 1'b0, 7'd0, 1'b1);
    checks++;
    if ({oWin_cnt, oReady, oOverflow} !== {16'hFFFF, 2'b10} || oWin_cnt !== m_cnt) begin
      errors++; $display("FAIL cnt_ffff: cnt %h ready %b ovf %b exp ffff 1 0", oWin_cnt, oReady, oOverflow);
    end
    step(1'b0, 7'd0, 32'd0, 1'b1, 1'b0, 7'd0, 1'b1);
    checks++;
    if (oWin_cnt !== 16'h0000 || oWin_cnt !== m_cnt) begin
      errors++; $display("FAIL cnt_wrap: cnt %h exp 0000", oWin_cnt);
    end
  endtask

  initial begin
    iReset = 1'b1;
    idle_inputs();
    test_reset();
    test_fill_read();
    test_overflow();
    test_back_to_back();
    test_full_release_same_cycle();
    test_underflow();
    test_reset_mid_window();
    test_random();
    test_win_cnt_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
